// File: rtl/wb_ram_responder.sv
// wb_ram_responder: Wishbone slave backed by a 2^CACHE_DEPTH x CACHE_WIDTH RAM.
// Each transfer passes through IDLE -> WAIT (WAIT_CYCLES cycles) -> RESP, one cycle.
// Writes commit per byte lane on the edge entering RESP. Reads load the word on
// that same edge and present it only while the ack is driven.
// Optional feature: define WB_RAM_RESPONDER_ADDR_CHECK_EN to terminate accesses
// outside [BASE_ADDR, BASE_ADDR + region size) with wb_err_o instead of aliasing.
module wb_ram_responder #(
    parameter int          CACHE_WIDTH = 128,
    parameter int          CACHE_DEPTH = 9,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              wb_adr_i,
    input  logic [CACHE_WIDTH-1:0]   wb_dat_i,
    output logic [CACHE_WIDTH-1:0]   wb_dat_o,
    input  logic                     wb_we_i,
    input  logic [CACHE_WIDTH/8-1:0] wb_sel_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_cyc_i,
    output logic                     wb_ack_o,
    output logic                     wb_err_o,
    output logic                     wb_rty_o
);

    localparam int SEL_WIDTH = CACHE_WIDTH / 8;
    localparam int ADR_LSB   = $clog2(SEL_WIDTH);
    localparam int WORDS     = 1 << CACHE_DEPTH;
    // Last value of the wait counter before moving to RESP.
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [CACHE_DEPTH-1:0]   idx_q, idx_d;
    logic                     we_q, we_d;
    logic [SEL_WIDTH-1:0]     sel_q, sel_d;
    logic [CACHE_WIDTH-1:0]   wdat_q, wdat_d;
    logic                     ok_q, ok_d;
    logic [CACHE_WIDTH-1:0]   rdat_q, rdat_d;
    logic [CACHE_WIDTH-1:0]   mem_q [WORDS];

    logic                     in_range_s;
    logic                     enter_resp_s;
    logic [CACHE_DEPTH-1:0]   cur_idx_s;
    logic                     cur_we_s;
    logic [SEL_WIDTH-1:0]     cur_sel_s;
    logic [CACHE_WIDTH-1:0]   cur_wdat_s;
    logic                     cur_ok_s;
    logic                     resp_live_s;
    logic                     unused_adr_s;

    // Byte-offset bits (and, without range checking, the bits above the index) are don't-care.
    assign unused_adr_s = ^wb_adr_i;

`ifdef WB_RAM_RESPONDER_ADDR_CHECK_EN
    logic [32:0] adr_ext_s;
    logic [32:0] lo_ext_s;
    logic [32:0] hi_ext_s;
    assign adr_ext_s  = {1'b0, wb_adr_i};
    assign lo_ext_s   = {1'b0, BASE_ADDR};
    assign hi_ext_s   = lo_ext_s + 33'(SEL_WIDTH * WORDS);
    assign in_range_s = (adr_ext_s >= lo_ext_s) && (adr_ext_s < hi_ext_s);
`else
    assign in_range_s = 1'b1;
`endif

    // In IDLE the request is taken straight from the bus (zero-wait case), otherwise from the latch.
    assign cur_idx_s  = (state_q == IDLE) ? wb_adr_i[ADR_LSB +: CACHE_DEPTH] : idx_q;
    assign cur_we_s   = (state_q == IDLE) ? wb_we_i    : we_q;
    assign cur_sel_s  = (state_q == IDLE) ? wb_sel_i   : sel_q;
    assign cur_wdat_s = (state_q == IDLE) ? wb_dat_i   : wdat_q;
    assign cur_ok_s   = (state_q == IDLE) ? in_range_s : ok_q;

    // Next-state, request latching and read-data capture for the transfer FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        we_d         = we_q;
        sel_d        = sel_q;
        wdat_d       = wdat_q;
        ok_d         = ok_q;
        rdat_d       = {CACHE_WIDTH{1'b0}};
        enter_resp_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    idx_d  = wb_adr_i[ADR_LSB +: CACHE_DEPTH];
                    we_d   = wb_we_i;
                    sel_d  = wb_sel_i;
                    wdat_d = wb_dat_i;
                    ok_d   = in_range_s;
                    cnt_d  = 4'd0;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d      = RESP;
                        enter_resp_s = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d      = RESP;
                    cnt_d        = 4'd0;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (enter_resp_s && !cur_we_s && cur_ok_s) begin
            rdat_d = mem_q[cur_idx_s];
        end else begin
            rdat_d = {CACHE_WIDTH{1'b0}};
        end
    end

    // State, counter and latched-request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= {CACHE_DEPTH{1'b0}};
            we_q    <= 1'b0;
            sel_q   <= {SEL_WIDTH{1'b0}};
            wdat_q  <= {CACHE_WIDTH{1'b0}};
            ok_q    <= 1'b0;
            rdat_q  <= {CACHE_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            ok_q    <= ok_d;
            rdat_q  <= rdat_d;
        end
    end

    // Byte-lane write commit on the edge entering RESP; contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp_s && cur_we_s && cur_ok_s) begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                if (cur_sel_s[i]) begin
                    mem_q[cur_idx_s][8*i +: 8] <= cur_wdat_s[8*i +: 8];
                end
            end
        end
    end

    // Terminations exist only in RESP and vanish as soon as the initiator drops cyc.
    assign resp_live_s = (state_q == RESP) && wb_cyc_i;
    assign wb_ack_o    = resp_live_s && ok_q;
`ifdef WB_RAM_RESPONDER_ADDR_CHECK_EN
    assign wb_err_o    = resp_live_s && !ok_q;
`else
    assign wb_err_o    = 1'b0;
`endif
    assign wb_rty_o    = 1'b0;
    assign wb_dat_o    = wb_ack_o ? rdat_q : {CACHE_WIDTH{1'b0}};

endmodule

// File: doc/wb_ram_responder.md
WB_RAM_RESPONDER -- requirements
Module: wb_ram_responder

Interface
REQ-001 SHALL have parameter CACHE_WIDTH, default 128, data bus width in bits (multiple of 8, power of two).
REQ-002 SHALL have parameter CACHE_DEPTH, default 9, log2 of the number of CACHE_WIDTH-bit words stored.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, byte address of word 0 (aligned to the region size).
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, wait states (0..15) inserted before the response.
REQ-005 SHALL derive localparam SEL_WIDTH = CACHE_WIDTH/8 and localparam ADR_LSB = log2(SEL_WIDTH).
REQ-006 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-007 clk  input  1  sole clock, all state updates on rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 wb_adr_i  input  32  byte address from initiator.
REQ-010 wb_dat_i  input  CACHE_WIDTH  write data.
REQ-011 wb_dat_o  output  CACHE_WIDTH  read data.
REQ-012 wb_we_i  input  1  1 = write, 0 = read.
REQ-013 wb_sel_i  input  SEL_WIDTH  byte lane enables; bit i covers data bits [8i+7:8i].
REQ-014 wb_stb_i  input  1  strobe, transfer request.
REQ-015 wb_cyc_i  input  1  bus cycle in progress.
REQ-016 wb_ack_o  output  1  normal termination.
REQ-017 wb_err_o  output  1  error termination.
REQ-018 wb_rty_o  output  1  retry termination; tied 0.

Function
REQ-019 SHALL store 2^CACHE_DEPTH words; word index = wb_adr_i[ADR_LSB+CACHE_DEPTH-1:ADR_LSB]; wb_adr_i[ADR_LSB-1:0] ignored.
REQ-020 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-021 IDLE: when wb_cyc_i & wb_stb_i sampled high, SHALL latch address, we, sel, data; go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-022 WAIT: SHALL count WAIT_CYCLES cycles, then go to RESP; if wb_cyc_i sampled low, SHALL return to IDLE with no write and no termination.
REQ-023 A write SHALL commit to memory on the edge entering RESP, updating only lanes whose latched sel bit is 1.
REQ-024 A read SHALL load wb_dat_o on the edge entering RESP with the addressed word's content before any write on that edge.
REQ-025 RESP SHALL last exactly one cycle, then return to IDLE unconditionally; max throughput is one transfer per WAIT_CYCLES+2 cycles.
REQ-026 wb_ack_o / wb_err_o SHALL be high only in RESP and only while wb_cyc_i is high; ack latency = WAIT_CYCLES+1 cycles after the request edge.
REQ-027 wb_dat_o SHALL be zero in every cycle except a RESP cycle terminating a read with ack.
REQ-028 wb_ack_o and wb_err_o SHALL never be high simultaneously.
REQ-029 Write with sel = 0 SHALL ack with memory unchanged.
REQ-030 cyc dropping during RESP SHALL suppress the termination outputs; a write already committed remains.
REQ-031 A request held on stb after an ack SHALL be sampled as a new transfer in the following IDLE cycle.

Reset
REQ-032 rst SHALL force state IDLE, wait counter 0, wb_ack_o=0, wb_err_o=0, wb_rty_o=0, wb_dat_o=0 on the next cycle.
REQ-033 rst during WAIT SHALL discard the pending transfer; no memory write occurs.
REQ-034 Memory contents SHALL NOT be cleared by rst.

Configuration
REQ-035 Macro WB_RAM_RESPONDER_ADDR_CHECK_EN SHALL control address range checking.
REQ-036 Defined: an address outside [BASE_ADDR, BASE_ADDR + SEL_WIDTH*2^CACHE_DEPTH) SHALL terminate with wb_err_o, no write, wb_dat_o = 0, same latency as ack.
REQ-037 Undefined: address bits above the index SHALL be ignored (aliasing), and wb_err_o SHALL be constant 0.

Verification (CACHE_WIDTH=128, CACHE_DEPTH=9, BASE_ADDR=0, WAIT_CYCLES=1)
REQ-038 Write adr 0x40, sel 0xFFFF, data 0x00112233_44556677_8899AABB_CCDDEEFF; read adr 0x40 -> each ack 2 cycles after the request edge, with read data equal to the written data.
REQ-039 Write adr 0x40, sel 0x000F, data all 0xAA bytes; read adr 0x40 -> 0x00112233_44556677_8899AABB_AAAAAAAA.
REQ-040 Read adr 0x2000: with macro defined -> wb_err_o for 1 cycle, ack 0, dat_o 0; without macro -> ack with word 0 contents.
REQ-041 Write adr 0x80 with cyc dropped in the WAIT cycle -> no ack or err; subsequent read of 0x80 returns the prior value.
REQ-042 rst asserted in the WAIT cycle of a write to 0x80 -> all outputs 0 next cycle; 0x80 unchanged.
REQ-043 Back-to-back reads 0x00 then 0x10 with stb held high -> acks spaced exactly 3 cycles apart, correct data on each.
